wb_perip_arbiter: RTL and testbench

Round-robin Wishbone arbiter that shares one peripheral slave port (GPIO, and later UART/timer) between up to four bus masters (core data port, debug module, DMA). It owns bus tenure: a grant is held for the full CYC of the winning master, and slave ACK and read data are routed back to it. A per-access watchdog aborts stalled accesses with an error strobe so a hung peripheral cannot lock the bus.

---
 rtl/wb_perip_arbiter_pkg.sv | 19 +
 rtl/wb_perip_arbiter_rr_arbiter.sv | 30 +++
 rtl/wb_perip_arbiter.sv | 158 +++++++++++++++
 tb/tb_wb_perip_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_perip_arbiter_pkg.sv
// Shared configuration for the peripheral-bus arbiter: bus width defaults,
// watchdog sizing and the arbiter FSM state encoding.
package wb_perip_arbiter_pkg;

    localparam int unsigned WB_AD_WIDTH_DEFAULT  = 32;
    localparam int unsigned WB_DAT_WIDTH_DEFAULT = 32;
    localparam int unsigned ARB_TIMEOUT_DEFAULT  = 255;

    // Round-robin pointer is sized for the largest supported master count (4).
    localparam int unsigned PTR_W  = 2;
    localparam int unsigned WDOG_W = 8;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BUSY  = 2'd1,
        ARB_ABORT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/wb_perip_arbiter_rr_arbiter.sv
// Combinational round-robin picker: returns a one-hot grant for the first
// active request found when searching upward from ptr, wrapping at NUM_M.
module rr_arbiter
    import wb_perip_arbiter_pkg::*;
#(
    parameter int unsigned NUM_M = 2
) (
    input  logic [NUM_M-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NUM_M-1:0] grant
);

    logic found;

    // Scan offsets from the pointer; the inner loop keeps every bit select
    // constant so the index never needs to be narrowed.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_M; i++) begin
            for (int unsigned j = 0; j < NUM_M; j++) begin
                if (!found && req[j] && ((32'(ptr) + i) % NUM_M == j)) begin
                    grant[j] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/wb_perip_arbiter.sv
// Round-robin Wishbone arbiter sharing one peripheral slave port between
// NUM_M masters, with a per-access watchdog that aborts stalled accesses.
module wb_perip_arbiter
    import wb_perip_arbiter_pkg::*;
#(
    parameter int unsigned NUM_M        = 2,
    parameter int unsigned WB_AD_WIDTH  = WB_AD_WIDTH_DEFAULT,
    parameter int unsigned WB_DAT_WIDTH = WB_DAT_WIDTH_DEFAULT,
    parameter int unsigned TIMEOUT      = ARB_TIMEOUT_DEFAULT
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_M-1:0]                    m_cyc_i,
    input  logic [NUM_M-1:0]                    m_stb_i,
    input  logic [NUM_M-1:0]                    m_we_i,
    input  logic [NUM_M*WB_AD_WIDTH-1:0]        m_addr_i,
    input  logic [NUM_M*WB_DAT_WIDTH-1:0]       m_wdata_i,
    input  logic [NUM_M*(WB_DAT_WIDTH/8)-1:0]   m_sel_i,
    output logic [WB_DAT_WIDTH-1:0]             m_rdata_o,
    output logic [NUM_M-1:0]                    m_ack_o,
    output logic [NUM_M-1:0]                    m_err_o,
    output logic                                s_cyc_o,
    output logic                                s_stb_o,
    output logic                                s_we_o,
    output logic [WB_AD_WIDTH-1:0]              s_addr_o,
    output logic [WB_DAT_WIDTH-1:0]             s_wdata_o,
    output logic [WB_DAT_WIDTH/8-1:0]           s_sel_o,
    input  logic [WB_DAT_WIDTH-1:0]             s_rdata_i,
    input  logic                                s_ack_i,
    output logic [NUM_M-1:0]                    grant_o
);

    localparam int unsigned SEL_W = WB_DAT_WIDTH / 8;
    // Abort is decided in the stalled cycle that would bring the count to
    // TIMEOUT, so an ACK arriving in that same cycle still wins.
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

    arb_state_t               state, state_nxt;
    logic [NUM_M-1:0]         grant, grant_nxt, arb_grant;
    logic [PTR_W-1:0]         rr_ptr, rr_ptr_nxt, ptr_after;
    logic [WDOG_W-1:0]        wdog, wdog_nxt;
    logic                     bus_on, err_on;
    logic                     cyc_g, stb_g, we_g;
    logic [WB_AD_WIDTH-1:0]   addr_g;
    logic [WB_DAT_WIDTH-1:0]  wdata_g;
    logic [SEL_W-1:0]         sel_g;

    rr_arbiter #(.NUM_M(NUM_M)) u_rr_arbiter (
        .req   (m_cyc_i),
        .ptr   (rr_ptr),
        .grant (arb_grant)
    );

    assign grant_o = grant;

    // Select the granted master's request signals and the pointer that
    // follows it once its tenure ends.
    always_comb begin
        cyc_g     = 1'b0;
        stb_g     = 1'b0;
        we_g      = 1'b0;
        addr_g    = '0;
        wdata_g   = '0;
        sel_g     = '0;
        ptr_after = '0;
        for (int unsigned i = 0; i < NUM_M; i++) begin
            if (grant[i]) begin
                cyc_g     = m_cyc_i[i];
                stb_g     = m_stb_i[i];
                we_g      = m_we_i[i];
                addr_g    = m_addr_i[i*WB_AD_WIDTH +: WB_AD_WIDTH];
                wdata_g   = m_wdata_i[i*WB_DAT_WIDTH +: WB_DAT_WIDTH];
                sel_g     = m_sel_i[i*SEL_W +: SEL_W];
                ptr_after = (i + 1 == NUM_M) ? '0 : PTR_W'(i + 1);
            end
        end
    end

    // State, grant, round-robin pointer and watchdog registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ARB_IDLE;
            grant  <= '0;
            rr_ptr <= '0;
            wdog   <= '0;
        end else begin
            state  <= state_nxt;
            grant  <= grant_nxt;
            rr_ptr <= rr_ptr_nxt;
            wdog   <= wdog_nxt;
        end
    end

    // Next-state logic: arbitrate in IDLE, hold tenure in BUSY, one-cycle ABORT.
    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant;
        rr_ptr_nxt = rr_ptr;
        wdog_nxt   = wdog;
        bus_on     = 1'b0;
        err_on     = 1'b0;
        unique case (state)
            ARB_IDLE: begin
                wdog_nxt = '0;
                if (|m_cyc_i) begin
                    grant_nxt = arb_grant;
                    state_nxt = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                bus_on = 1'b1;
                if (!cyc_g) begin
                    rr_ptr_nxt = ptr_after;
                    grant_nxt  = '0;
                    wdog_nxt   = '0;
                    state_nxt  = ARB_IDLE;
                end else if (!stb_g || s_ack_i) begin
                    wdog_nxt = '0;
                end else if (wdog == WDOG_LAST) begin
                    wdog_nxt  = '0;
                    state_nxt = ARB_ABORT;
                end else begin
                    wdog_nxt = wdog + WDOG_W'(1);
                end
            end
            ARB_ABORT: begin
                err_on   = 1'b1;
                wdog_nxt = '0;
                if (cyc_g) begin
                    state_nxt = ARB_BUSY;
                end else begin
                    rr_ptr_nxt = ptr_after;
                    grant_nxt  = '0;
                    state_nxt  = ARB_IDLE;
                end
            end
            default: begin
                grant_nxt = '0;
                state_nxt = ARB_IDLE;
            end
        endcase
    end

    // Slave-side mux and master-side response routing; everything is gated
    // by state so an async reset drops all outputs immediately.
    always_comb begin
        s_cyc_o   = bus_on & cyc_g;
        s_stb_o   = bus_on & stb_g;
        s_we_o    = bus_on & we_g;
        s_addr_o  = bus_on ? addr_g  : '0;
        s_wdata_o = bus_on ? wdata_g : '0;
        s_sel_o   = bus_on ? sel_g   : '0;
        m_rdata_o = bus_on ? s_rdata_i : '0;
        m_ack_o   = (bus_on && cyc_g && stb_g && s_ack_i) ? grant : '0;
        m_err_o   = err_on ? grant : '0;
    end

endmodule

// File: tb/tb_wb_perip_arbiter.sv
// Directed self-checking bench for wb_perip_arbiter (4 masters, TIMEOUT=4).
module tb_wb_perip_arbiter;

    localparam int unsigned NM = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;
    localparam logic [AW-1:0] GPIO_PORT_ADDR = 32'h4000_0000;

    logic              clk;
    logic              rst_n;
    logic [NM-1:0]     m_cyc, m_stb, m_we;
    logic [NM*AW-1:0]  m_addr;
    logic [NM*DW-1:0]  m_wdata;
    logic [NM*SW-1:0]  m_sel;
    logic [DW-1:0]     m_rdata;
    logic [NM-1:0]     m_ack, m_err, grant;
    logic              s_cyc, s_stb, s_we;
    logic [AW-1:0]     s_addr;
    logic [DW-1:0]     s_wdata, s_rdata;
    logic [SW-1:0]     s_sel;
    logic              s_ack;

    int checks = 0;
    int errors = 0;

    wb_perip_arbiter #(
        .NUM_M        (NM),
        .WB_AD_WIDTH  (AW),
        .WB_DAT_WIDTH (DW),
        .TIMEOUT      (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m_cyc_i   (m_cyc),
        .m_stb_i   (m_stb),
        .m_we_i    (m_we),
        .m_addr_i  (m_addr),
        .m_wdata_i (m_wdata),
        .m_sel_i   (m_sel),
        .m_rdata_o (m_rdata),
        .m_ack_o   (m_ack),
        .m_err_o   (m_err),
        .s_cyc_o   (s_cyc),
        .s_stb_o   (s_stb),
        .s_we_o    (s_we),
        .s_addr_o  (s_addr),
        .s_wdata_o (s_wdata),
        .s_sel_o   (s_sel),
        .s_rdata_i (s_rdata),
        .s_ack_i   (s_ack),
        .grant_o   (grant)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int unsigned k, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic w);
        m_addr[k*AW +: AW]  = a;
        m_wdata[k*DW +: DW] = d;
        m_sel[k*SW +: SW]   = '1;
        m_we[k]             = w;
    endtask

    task automatic do_reset();
        m_cyc = '0; m_stb = '0; m_we = '0;
        m_addr = '0; m_wdata = '0; m_sel = '0;
        s_ack = 1'b0; s_rdata = '0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        m_cyc = '0; m_stb = '0; m_we = '0;
        m_addr = '0; m_wdata = '0; m_sel = '0;
        s_rdata = 32'hFFFF_FFFF; s_ack = 1'b1;
        #2;
        // reset state, with a spurious slave ACK present
        chk("rst_grant", grant, 0);
        chk("rst_s_cyc", s_cyc, 0);
        chk("rst_s_stb", s_stb, 0);
        chk("rst_m_ack", m_ack, 0);
        chk("rst_m_err", m_err, 0);
        chk("rst_m_rdata", m_rdata, 0);

        // single master 0 write of 0x1 to the GPIO port
        do_reset();
        step(); set_m(0, GPIO_PORT_ADDR, 32'h1, 1'b1); m_cyc[0] = 1; m_stb[0] = 1; #1;
        chk("t1_grant_latency", grant, 0);
        chk("t1_s_cyc_latency", s_cyc, 0);
        step(); #1;
        chk("t1_grant", grant, 4'b0001);
        chk("t1_s_cyc", s_cyc, 1);
        chk("t1_s_we", s_we, 1);
        chk("t1_s_addr", s_addr, GPIO_PORT_ADDR);
        chk("t1_s_wdata", s_wdata, 32'h1);
        chk("t1_s_sel", s_sel, 4'hF);
        chk("t1_ack_wait", m_ack, 0);
        step(); s_ack = 1; s_rdata = 32'hDEAD_BEEF; #1;
        chk("t1_ack", m_ack, 4'b0001);
        chk("t1_rdata", m_rdata, 32'hDEAD_BEEF);
        chk("t1_err", m_err, 0);
        step(); s_ack = 0; m_cyc[0] = 0; m_stb[0] = 0; #1;
        chk("t1_s_cyc_drop", s_cyc, 0);
        chk("t1_ack_once", m_ack, 0);
        step(); #1;
        chk("t1_grant_clear", grant, 0);

        // simultaneous masters 0 and 1 alternate
        do_reset();
        step(); m_cyc[1:0] = 2'b11; m_stb[1:0] = 2'b11; #1;
        chk("t2_idle", grant, 0);
        step(); s_ack = 1; #1;
        chk("t2_first_m0", grant, 4'b0001);
        chk("t2_ack_m0_only", m_ack, 4'b0001);
        step(); s_ack = 0; m_cyc[0] = 0; m_stb[0] = 0; #1;
        chk("t2_s_cyc_drop", s_cyc, 0);
        step(); m_cyc[0] = 1; m_stb[0] = 1; #1;
        chk("t2_dead1", grant, 0);
        step(); s_ack = 1; #1;
        chk("t2_second_m1", grant, 4'b0010);
        chk("t2_ack_m1", m_ack, 4'b0010);
        step(); s_ack = 0; m_cyc[1] = 0; m_stb[1] = 0; #1;
        step(); m_cyc[1] = 1; m_stb[1] = 1; #1;
        chk("t2_dead2", grant, 0);
        step(); m_cyc[0] = 0; m_stb[0] = 0; #1;
        chk("t2_third_m0", grant, 4'b0001);
        step(); #1;
        step(); #1;
        chk("t2_fourth_m1", grant, 4'b0010);
        m_cyc = '0; m_stb = '0;

        // master 1 holds CYC across 3 STBs while master 0 waits
        do_reset();
        step(); set_m(1, 32'h4000_0010, 32'h11, 1'b0); m_cyc[1] = 1; m_stb[1] = 1; #1;
        chk("t3_idle", grant, 0);
        step(); set_m(0, 32'h4000_0020, 32'h22, 1'b1); m_cyc[0] = 1; m_stb[0] = 1; s_ack = 1; #1;
        chk("t3_grant_m1", grant, 4'b0010);
        chk("t3_addr_a0", s_addr, 32'h4000_0010);
        chk("t3_ack_a0", m_ack, 4'b0010);
        step(); m_stb[1] = 0; #1;
        chk("t3_stb_gap", s_stb, 0);
        chk("t3_ack_stb_low", m_ack, 0);
        chk("t3_hold_gap", grant, 4'b0010);
        step(); m_stb[1] = 1; m_addr[1*AW +: AW] = 32'h4000_0014; #1;
        chk("t3_addr_a1", s_addr, 32'h4000_0014);
        chk("t3_ack_a1", m_ack, 4'b0010);
        step(); m_addr[1*AW +: AW] = 32'h4000_0018; #1;
        chk("t3_addr_a2", s_addr, 32'h4000_0018);
        chk("t3_hold", grant, 4'b0010);
        step(); s_ack = 0; m_cyc[1] = 0; m_stb[1] = 0; #1;
        chk("t3_release", s_cyc, 0);
        step(); #1;
        chk("t3_dead", grant, 0);
        step(); s_ack = 1; #1;
        chk("t3_grant_m0", grant, 4'b0001);
        chk("t3_addr_b0", s_addr, 32'h4000_0020);
        chk("t3_ack_b0", m_ack, 4'b0001);
        step(); m_addr[0 +: AW] = 32'h4000_0024; #1;
        chk("t3_addr_b1", s_addr, 32'h4000_0024);
        step(); m_addr[0 +: AW] = 32'h4000_0028; #1;
        chk("t3_addr_b2", s_addr, 32'h4000_0028);
        step(); s_ack = 0; m_cyc = '0; m_stb = '0; #1;

        // watchdog abort after 4 stalled cycles, then ACK exactly at the limit
        do_reset();
        step(); m_cyc[1:0] = 2'b11; m_stb[1:0] = 2'b11; #1;
        step(); #1;
        chk("t4_grant_m0", grant, 4'b0001);
        chk("t4_err_c1", m_err, 0);
        step(); #1;
        chk("t4_err_c2", m_err, 0);
        step(); #1;
        chk("t4_err_c3", m_err, 0);
        step(); #1;
        chk("t4_err_c4", m_err, 0);
        chk("t4_s_cyc_c4", s_cyc, 1);
        step(); m_cyc[0] = 0; m_stb[0] = 0; #1;
        chk("t4_err", m_err, 4'b0001);
        chk("t4_abort_s_cyc", s_cyc, 0);
        chk("t4_abort_s_stb", s_stb, 0);
        chk("t4_abort_ack", m_ack, 0);
        step(); #1;
        chk("t4_err_once", m_err, 0);
        chk("t4_dead", grant, 0);
        step(); #1;
        chk("t4_grant_m1", grant, 4'b0010);
        step(); #1;
        step(); #1;
        step(); s_ack = 1; #1;
        chk("t5_ack_at_limit", m_ack, 4'b0010);
        chk("t5_err_at_limit", m_err, 0);
        step(); s_ack = 0; #1;
        chk("t5_no_abort_err", m_err, 0);
        chk("t5_no_abort_cyc", s_cyc, 1);
        m_cyc[1] = 0; m_stb[1] = 0;
        step(); s_ack = 1; #1;
        chk("t5_spurious_ack", m_ack, 0);
        chk("t5_idle_rdata", m_rdata, 0);
        s_ack = 0;

        // async reset mid-access, then rr pointer restarts at master 0
        do_reset();
        step(); set_m(2, 32'h4000_0030, 32'h33, 1'b1); m_cyc[2] = 1; m_stb[2] = 1; #1;
        step(); s_ack = 1; #1;
        chk("t6_grant_m2", grant, 4'b0100);
        step(); s_ack = 0; m_cyc[2] = 0; m_stb[2] = 0; #1;
        step(); m_cyc[2] = 1; m_stb[2] = 1; #1;
        step(); #1;
        step(); s_ack = 1; #1;
        chk("t6_grant_m2_again", grant, 4'b0100);
        chk("t6_ack_pre_rst", m_ack, 4'b0100);
        rst_n = 1'b0; #1;
        chk("t6_rst_s_cyc", s_cyc, 0);
        chk("t6_rst_grant", grant, 0);
        chk("t6_rst_ack", m_ack, 0);
        chk("t6_rst_err", m_err, 0);
        s_ack = 0; m_cyc = '1; m_stb = '1;
        @(negedge clk);
        rst_n = 1'b1;
        step(); #1;
        chk("t6_four_way_m0", grant, 4'b0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
